// File: rtl/mux_rr_n.sv
// Registered N-to-1 word multiplexer with valid/ready on every port.
// Selection is either a direct channel index or round-robin arbitration.
module mux_rr_n #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned CHANNELS = 8,
   parameter int unsigned SEL_W    = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_chan_q, out_chan_d;
   logic             out_valid_q, out_valid_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;

   logic             adv;
   logic             grant_vld;
   logic [SEL_W-1:0] grant_idx;
   logic [WIDTH-1:0] grant_word;

   assign adv = ~out_valid_q | out_ready;

   // Round-robin scan is split into two ascending passes (k >= ptr, then k < ptr),
   // which is the wrap-around search without any modulo arithmetic.
   always_comb begin
      grant_vld  = 1'b0;
      grant_idx  = '0;
      grant_word = '0;
      if (!mode) begin
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (in_valid[k] && sel == SEL_W'(k)) begin
               grant_vld  = 1'b1;
               grant_idx  = SEL_W'(k);
               grant_word = in_data[k*WIDTH +: WIDTH];
            end
         end
      end else begin
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (!grant_vld && in_valid[k] && SEL_W'(k) >= ptr_q) begin
               grant_vld  = 1'b1;
               grant_idx  = SEL_W'(k);
               grant_word = in_data[k*WIDTH +: WIDTH];
            end
         end
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (!grant_vld && in_valid[k] && SEL_W'(k) < ptr_q) begin
               grant_vld  = 1'b1;
               grant_idx  = SEL_W'(k);
               grant_word = in_data[k*WIDTH +: WIDTH];
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         in_ready[k] = rst_n & adv & grant_vld & (grant_idx == SEL_W'(k));
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (adv) begin
         if (grant_vld) begin
            out_data_d  = grant_word;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (mode) begin
               ptr_d = (grant_idx == SEL_W'(CHANNELS-1)) ? '0 : grant_idx + SEL_W'(1);
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_valid = out_valid_q;

endmodule
